// File: rtl/alu_pkg.sv
// Shared opcode and shift-type encodings for the RV64I execute-stage ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// The shift opcodes are laid out so that alu_ctrl[1:0] maps straight onto
// the shifter's 2-bit shift-type select (SLL=00, SRL=01, SRA=10).
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  // Shift opcodes occupy 1000..1010; 1011 is reserved and must not match.
  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/base_alu_shifter.sv
// Combinational barrel shifter: SLL / SRL / SRA of data by shamt.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   data       - value to shift
//   shamt      - shift amount, log2(XLEN) bits; upper operand bits never reach here
//   shift_type - 00 SLL, 01 SRL, 10 SRA, 11 yields 0
//   shifted    - shift result
module base_alu_shifter
  import alu_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  shamt,
  input  logic [1:0]      shift_type,
  output logic [XLEN-1:0] shifted
);

  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] sra_res;

  assign sll_res = data << shamt;
  assign srl_res = data >> shamt;
  // Arithmetic shift needs a signed left operand so the fill comes from data[XLEN-1].
  assign sra_res = $unsigned($signed(data) >>> shamt);

  always_comb begin
    shifted = '0;
    case (shift_type)
      SHIFT_SLL: shifted = sll_res;
      SHIFT_SRL: shifted = srl_res;
      SHIFT_SRA: shifted = sra_res;
      default:   shifted = '0;
    endcase
  end

endmodule

// File: rtl/base_alu.sv
// RV64I execute-stage integer ALU: add/sub, logic, signed/unsigned compare, shifts.
// Latency: 1 cycle, result/zero/out_valid registered; one op per cycle.
// Backpressure: none; every in_valid op completes, out_valid low holds result/zero.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - op1/op2/alu_ctrl valid this cycle
//   op1, op2      - operands (op2 low log2(XLEN) bits are the shift amount)
//   alu_ctrl      - operation select (see alu_pkg)
//   result        - registered result
//   out_valid     - result belongs to an op issued the previous cycle
//   zero          - registered, result of that op is all zeros
module base_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            out_valid,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] alu_res;
  logic            slt_lt;
  logic            sltu_lt;

  // Only the low shamt bits of op2 feed the shifter, so the upper bits
  // cannot influence a shift result even when they are unknown.
  base_alu_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .data       (op1),
    .shamt      (op2[SHW-1:0]),
    .shift_type (alu_ctrl[1:0]),
    .shifted    (shift_res)
  );

  assign slt_lt  = $signed(op1) < $signed(op2);
  assign sltu_lt = op1 < op2;

  // Each arm reads only the operands its op uses; NOT never touches op2.
  always_comb begin
    alu_res = '0;
    if (is_shift_op(alu_ctrl)) begin
      alu_res = shift_res;
    end else begin
      case (alu_ctrl)
        ALU_ADD:  alu_res = op1 + op2;
        ALU_SUB:  alu_res = op1 - op2;
        ALU_AND:  alu_res = op1 & op2;
        ALU_OR:   alu_res = op1 | op2;
        ALU_XOR:  alu_res = op1 ^ op2;
        ALU_NOT:  alu_res = ~op1;
        ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_lt};
        ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, sltu_lt};
        default:  alu_res = '0;  // reserved opcodes still complete with 0
      endcase
    end
  end

  // Reset wins over in_valid, so an op issued alongside rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_base_alu.sv
module tb_base_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] op1;
  logic [63:0] op2;
  logic [3:0]  alu_ctrl;
  logic [63:0] result;
  logic        out_valid;
  logic        zero;

  int vectors;
  int miscompares;

  base_alu #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op1       (op1),
    .op2       (op2),
    .alu_ctrl  (alu_ctrl),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, then check result/zero/out_valid one cycle later.
  task automatic run_op(input string tag, input logic [3:0] ctrl,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_zero);
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = ctrl;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, {63'd0, zero}, {63'd0, exp_zero});
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b1;
    alu_ctrl    = ALU_ADD;
    op1         = 64'd3;
    op2         = 64'd4;

    // Reset overrides a pending in_valid.
    repeat (3) @(posedge clk);
    #1;
    check("rst.result", result, 64'd0);
    check("rst.zero", {63'd0, zero}, 64'd0);
    check("rst.valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Arithmetic and logic
    run_op("add",  ALU_ADD, 64'd10, 64'd15, 64'd25, 1'b0);
    run_op("sub",  ALU_SUB, 64'd20, 64'd5,  64'd15, 1'b0);
    run_op("sub0", ALU_SUB, 64'd5,  64'd5,  64'd0,  1'b1);
    run_op("and",  ALU_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0);
    run_op("or",   ALU_OR,  64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0);
    run_op("xor",  ALU_XOR, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0);
    run_op("not",  ALU_NOT, 64'hFF00, 64'bx,    64'hFFFF_FFFF_FFFF_00FF, 1'b0);
    run_op("addwrap", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);

    // Compares
    run_op("slt_neg",  ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd1, 1'b0);
    run_op("sltu",     ALU_SLTU, 64'd5, 64'd3, 64'd0, 1'b1);
    run_op("sltu_big", ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd0, 1'b1);
    run_op("slt_pos",  ALU_SLT,  64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1);
    run_op("sltu_lt",  ALU_SLTU, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd1, 1'b0);

    // Shifts
    run_op("sll",    ALU_SLL, 64'd1,  64'd4, 64'd16, 1'b0);
    run_op("srl",    ALU_SRL, 64'd16, 64'd2, 64'd4,  1'b0);
    run_op("sra",    ALU_SRA, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    run_op("srl_hi", ALU_SRL, 64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 1'b0);
    run_op("sll0",   ALU_SLL, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_op("sll_hi0", ALU_SLL, 64'h0000_0000_0000_00A5, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0000_0000_0000_00A5, 1'b0);
    run_op("sra63",  ALU_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("srl63",  ALU_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0);

    // Back-to-back ADD, SUB, XOR then an idle cycle
    run_op("b2b_add", ALU_ADD, 64'd1,   64'd2,   64'd3,   1'b0);
    run_op("b2b_sub", ALU_SUB, 64'd10,  64'd4,   64'd6,   1'b0);
    run_op("b2b_xor", ALU_XOR, 64'hF0,  64'h0F,  64'hFF,  1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = ALU_SUB;
    op1      = 64'd9;
    op2      = 64'd9;
    @(posedge clk);
    #1;
    check("idle.valid", {63'd0, out_valid}, 64'd0);
    check("idle.result", result, 64'hFF);
    check("idle.zero", {63'd0, zero}, 64'd0);

    // Reserved opcode still completes
    run_op("rsvd", 4'b1100, 64'hFFFF, 64'hFFFF, 64'd0, 1'b1);
    run_op("rsvd_b", 4'b1011, 64'h1, 64'h1, 64'd0, 1'b1);

    // Reset in the same cycle as an ADD issue
    run_op("pre_rst", ALU_ADD, 64'd7, 64'd8, 64'd15, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    op1      = 64'd100;
    op2      = 64'd1;
    @(posedge clk);
    #1;
    check("rstop.result", result, 64'd0);
    check("rstop.zero", {63'd0, zero}, 64'd0);
    check("rstop.valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("postrst.valid", {63'd0, out_valid}, 64'd0);
    check("postrst.result", result, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/base_alu.md
Name: base_alu

Overview:
- 64-bit integer ALU for the RV64I execute stage: add/sub, bitwise logic, signed/unsigned compare, and shifts, selected by a 4-bit control code.
- Operation logic is combinational; the result is registered, giving a fixed one-cycle latency with a valid flag.
- Sits between the operand-select muxes and the writeback/forwarding path.

Parameters:
- XLEN, 64, operand and result width; the shift amount is log2(XLEN) bits (6 at default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  op1/op2/alu_ctrl are valid this cycle
- op1  input  XLEN  first operand; the only operand for NOT
- op2  input  XLEN  second operand; shift amount for shifts
- alu_ctrl  input  4  operation select
- result  output  XLEN  registered operation result
- out_valid  output  1  result holds the output for an in_valid issued one cycle earlier
- zero  output  1  registered; high when the result of that same operation is all zeros

Behaviour:
- Opcode table:
  - 0000 ADD: op1+op2, modulo 2^64, carry discarded.
  - 0001 SUB: op1-op2, modulo 2^64.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT: ~op1; op2 ignored.
  - 0110 SLT: 1 if $signed(op1) < $signed(op2), else 0; zero-extended to 64 bits.
  - 0111 SLTU: same as SLT but an unsigned compare.
  - 1000 SLL: op1 << op2[5:0].
  - 1001 SRL: op1 >> op2[5:0], zero fill.
  - 1010 SRA: op1 >>> op2[5:0], sign fill from op1[63].
  - 1011-1111 reserved: result 0, zero=1. The op still completes, so out_valid=1.
- Shifts: only op2[5:0] is used; op2[63:6] is ignored. A shift amount of 0 returns op1 unchanged.
- Latency: exactly 1 cycle.
  - Edge N with in_valid=1: result, zero and out_valid=1 update from that cycle's inputs.
  - Edge N with in_valid=0: out_valid goes 0, and result and zero hold their previous values.
- Throughput: one operation per cycle. There is no backpressure and no internal state beyond the output registers.
- Reset: while rst=1 at a rising edge, result=0, zero=0 and out_valid=0, overriding any in_valid. The first operation accepted is one presented on the edge after rst deasserts.
- Reset mid-stream: an operation issued in the same cycle as rst is dropped and never produces out_valid.
- Inputs are don't-care when in_valid=0. X on ignored operand bits (op2 for NOT, op2[63:6] for shifts) must not propagate to the result.
- No exceptions or overflow flags; signed overflow wraps silently.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_OR=0011, ALU_XOR=0100, ALU_NOT=0101, ALU_SLT=0110, ALU_SLTU=0111, ALU_SLL=1000, ALU_SRL=1001, ALU_SRA=1010;
  - an XLEN default.
- One natural sub-module, base_alu_shifter: combinational SLL/SRL/SRA over a 6-bit shamt, 2-bit shift-type select.
- Add/sub, logic and compare stay inline in a combinational case statement.
- Output registers form a single always block.

Test Plan:
- Reset, then the arithmetic and logic ops, each with in_valid=1, checking result one cycle later:
  - ADD 10+15 → result=25, zero=0.
  - SUB 20-5 → 15.
  - SUB 5-5 → 0, zero=1.
  - AND 0xF0F0 & 0x0FF0 → 0x00F0.
  - OR → 0xFFF0.
  - XOR 0xFF00 ^ 0x0FF0 → 0xF0F0.
  - NOT op1=0xFF00 (op2 = X) → 0xFFFFFFFFFFFF00FF.
- Compares:
  - SLT op1=-5, op2=3 → 1.
  - SLTU op1=5, op2=3 → 0.
  - SLTU op1=-5 (0xFFFF...FFFB), op2=3 → 0.
  - SLT op1=3, op2=-5 → 0.
- Shifts:
  - SLL 1<<4 → 16.
  - SRL 16>>2 → 4.
  - SRA -16>>>2 → -4 (0xFFFFFFFFFFFFFFFC).
  - SRL 0x8000000000000000 by op2=0x41 (shamt 1) → 0x4000000000000000.
  - SLL by op2=0 → op1 unchanged.
- Back-to-back issue of ADD, SUB, XOR on consecutive cycles → three consecutive out_valid=1 cycles with results in issue order. A following in_valid=0 cycle → out_valid=0 and result holds the XOR value.
- Reserved opcode 1100 with op1=op2=0xFFFF → result=0, zero=1, out_valid=1.
- Reset interaction: assert rst in the same cycle as an ADD issue → next cycle result=0, zero=0, out_valid=0; the ADD result never appears.
